// File: rtl/div.sv
// Multi-cycle 32-bit signed/unsigned divider, restoring shift-subtract, one quotient
// bit per clock. result_o = {remainder, quotient}, held in END until start_i drops.
module div (
  input  logic        clk,
  input  logic        Rst_n,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BYZERO = 2'd1,
    ON     = 2'd2,
    END    = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [64:0] work_q, work_d;
  logic [31:0] divisor_q, divisor_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;

  logic [32:0] trial_s;
  logic [31:0] quo_s;
  logic [31:0] rem_s;

  function automatic logic [31:0] magnitude(input logic is_signed, input logic [31:0] v);
    if (is_signed && v[31]) begin
      return 32'd0 - v;
    end else begin
      return v;
    end
  endfunction

  assign trial_s = {1'b0, work_q[63:32]} - {1'b0, divisor_q};
  assign quo_s   = neg_quo_q ? (32'd0 - work_q[31:0])  : work_q[31:0];
  assign rem_s   = neg_rem_q ? (32'd0 - work_q[64:33]) : work_q[64:33];

  // Next-state and datapath update for the divider FSM.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    ready_d   = ready_q;
    case (state_q)
      FREE: begin
        if (start_i && !annul_i) begin
          // Sign corrections are captured here so later operand changes cannot leak in.
          divisor_d = magnitude(signed_div_i, opdata2_i);
          neg_quo_d = signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
          neg_rem_d = signed_div_i & opdata1_i[31];
          work_d    = {32'd0, magnitude(signed_div_i, opdata1_i), 1'b0};
          cnt_d     = 6'd0;
          state_d   = (opdata2_i == 32'd0) ? BYZERO : ON;
        end else begin
          state_d = FREE;
        end
      end
      BYZERO: begin
        state_d  = END;
        result_d = 64'd0;
        ready_d  = 1'b1;
      end
      ON: begin
        if (annul_i || !start_i) begin
          state_d  = FREE;
          result_d = 64'd0;
          ready_d  = 1'b0;
        end else if (cnt_q == 6'd32) begin
          state_d  = END;
          result_d = {rem_s, quo_s};
          ready_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 6'd1;
          if (trial_s[32]) begin
            work_d = {work_q[63:0], 1'b0};
          end else begin
            work_d = {trial_s[31:0], work_q[31:0], 1'b1};
          end
        end
      end
      END: begin
        if (start_i) begin
          state_d = END;
        end else begin
          state_d  = FREE;
          result_d = 64'd0;
          ready_d  = 1'b0;
        end
      end
      default: begin
        state_d  = FREE;
        result_d = 64'd0;
        ready_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!Rst_n) begin
      state_q   <= FREE;
      cnt_q     <= 6'd0;
      work_q    <= 65'd0;
      divisor_q <= 32'd0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= 64'd0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div.sv
// Scoreboard bench for div: the driver queues expected {rem, quo} and latency,
// and an independent monitor checks every ready_o rise and hold cycle.
module tb_div;

  logic        clk = 1'b0;
  logic        Rst_n;
  logic        signed_div;
  logic [31:0] op1, op2;
  logic        start, annul;
  logic [63:0] result;
  logic        ready;

  always #5 clk = ~clk;

  div dut (
    .clk          (clk),
    .Rst_n        (Rst_n),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  typedef struct {
    logic [63:0] res;
    int          e0;
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic        ready_prev = 1'b0;
  logic [63:0] held = 64'd0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer division, C-style truncation, divide-by-zero gives 0.
  function automatic logic [63:0] ref_div(input bit s, input logic [31:0] a, input logic [31:0] b);
    int          sa, sb;
    logic [31:0] q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
      sa = a;
      sb = b;
      q  = sa / sb;
      r  = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Monitor: pops the scoreboard on each ready_o rise, checks stability while high.
  always @(negedge clk) begin
    if (ready === 1'b1 && ready_prev !== 1'b1) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_ready: ready_o=1 with no request pending, required 0 (t=%0t)", $time);
      end else begin
        exp_t cur;
        cur = sb_q.pop_front();
        check("result", result, cur.res);
        check("latency", 64'(cyc - cur.e0), 64'(cur.lat));
        held = cur.res;
      end
    end else if (ready === 1'b1) begin
      check("hold", result, held);
    end
    ready_prev = ready;
  end

  // Full request: start held until ready, held `hold` more cycles, then dropped.
  task automatic run_div(input bit s, input logic [31:0] a, input logic [31:0] b, input int hold);
    exp_t e;
    bit   got;
    e.res = ref_div(s, a, b);
    e.e0  = cyc + 1;
    e.lat = (b == 32'd0) ? 1 : 33;
    sb_q.push_back(e);
    signed_div = s;
    op1        = a;
    op2        = b;
    start      = 1'b1;
    @(negedge clk);
    op1        = $urandom;
    op2        = $urandom;
    signed_div = 1'($urandom);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (ready === 1'b1) got = 1'b1;
      else @(negedge clk);
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: ready_o=0 after 40 cycles, required 1 (a=%h b=%h)", a, b);
      sb_q.delete();
    end
    repeat (hold) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("drop_ready", 64'(ready), 64'd0);
    check("drop_result", result, 64'd0);
  endtask

  // Aborted request: mode 0 = annul pulse, 1 = start dropped, 2 = reset, at cnt=steps.
  task automatic abort_div(input logic [31:0] a, input logic [31:0] b, input int steps, input int mode);
    signed_div = 1'b0;
    op1        = a;
    op2        = b;
    start      = 1'b1;
    @(negedge clk);
    repeat (steps) @(negedge clk);
    case (mode)
      0: annul = 1'b1;
      1: start = 1'b0;
      default: begin
        Rst_n = 1'b0;
        start = 1'b0;
      end
    endcase
    @(negedge clk);
    check("abort_ready", 64'(ready), 64'd0);
    check("abort_result", result, 64'd0);
    annul = 1'b0;
    start = 1'b0;
    Rst_n = 1'b1;
    repeat (36) @(negedge clk);
    check("abort_no_ready", 64'(ready), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    Rst_n      = 1'b0;
    start      = 1'b0;
    annul      = 1'b0;
    signed_div = 1'b0;
    op1        = 32'd0;
    op2        = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_ready", 64'(ready), 64'd0);
    check("reset_result", result, 64'd0);
    Rst_n = 1'b1;
    run_div(1'b0, 32'd100, 32'd7, 3);
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0);
    run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 1);
    run_div(1'b0, 32'h1234_5678, 32'd0, 2);
    run_div(1'b1, 32'h1234_5678, 32'd0, 0);
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    run_div(1'b0, 32'hFFFF_FFFF, 32'd1, 0);
    run_div(1'b1, 32'h8000_0000, 32'h8000_0000, 0);
    abort_div(32'd1000, 32'd3, 10, 0);
    run_div(1'b0, 32'd9, 32'd3, 0);
    abort_div(32'hDEAD_BEEF, 32'd17, 20, 2);
    abort_div(32'd55, 32'd5, 5, 1);
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a, b;
      int          sel;
      a   = $urandom;
      sel = int'($urandom_range(0, 4));
      case (sel)
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'd0 - 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      run_div(1'($urandom), a, b, int'($urandom_range(0, 2)));
    end
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
